// File: rtl/ofm_collector_pkg.sv
// Shared definitions for the OFM write-back path: run counter width and
// collector FSM state encoding.
package ofm_collector_pkg;

    localparam int unsigned CNT_W = 9;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDrain   = 2'd2,
        StDone    = 2'd3
    } ofm_state_e;

endpackage

// File: rtl/ofm_fifo.sv
// First-word fall-through FIFO buffering OFM words between the convolution
// core and the OFM memory write port.
module ofm_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A pop on a full FIFO does not free a slot for a push in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ofm_collector.sv
// Collects a run of OFM words from the convolution core through a small FIFO
// and writes them to consecutive OFM memory addresses.
module ofm_collector
    import ofm_collector_pkg::*;
#(
    parameter int unsigned P      = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  total_cnt,
    input  logic              ofm_write,
    input  logic [DATA_W-1:0] ofm_data,
    output logic              ofm_full,
    output logic              mem_wr_en,
    output logic [CNT_W-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              overflow
);

    localparam cnt_t CNT_ONE = cnt_t'(1);

    if (P == 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("ofm_collector: P must be nonzero and DEPTH a power of two >= 2");
    end

    ofm_state_e        r_state;
    cnt_t              r_total;
    cnt_t              r_acc_cnt;
    cnt_t              r_wr_cnt;
    logic              r_overflow;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_active;
    logic              w_push;
    logic              w_drop;
    logic              w_xfer;

    assign w_active  = (r_state == StCollect) || (r_state == StDrain);
    assign w_push    = (r_state == StCollect) && ofm_write && !w_fifo_full;
    assign w_drop    = (r_state == StCollect) && ofm_write && w_fifo_full;
    assign mem_wr_en = w_active && !w_fifo_empty;
    assign w_xfer    = mem_wr_en && mem_ready;

    ofm_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (ofm_data),
        .i_pop   (w_xfer),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_total    <= '0;
            r_acc_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_acc_cnt <= r_acc_cnt + CNT_ONE;
            end
            if (w_xfer) begin
                r_wr_cnt <= r_wr_cnt + CNT_ONE;
            end
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_total    <= total_cnt;
                        r_acc_cnt  <= '0;
                        r_wr_cnt   <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= (total_cnt == '0) ? StDone : StCollect;
                    end
                end
                StCollect: begin
                    if (w_push && (r_acc_cnt + CNT_ONE) == r_total) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_xfer && (r_wr_cnt + CNT_ONE) == r_total) begin
                        r_state <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // The write counter doubles as the run-relative address; 9 bits wrap 511 -> 0.
    assign mem_addr  = r_wr_cnt;
    assign mem_wdata = mem_wr_en ? w_head : '0;
    assign ofm_full  = w_fifo_full;
    assign done      = (r_state == StDone);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ofm_collector.sv
// Randomized and directed bench for ofm_collector; a queue-based reference model
// feeds a scoreboard that a negedge monitor checks against the memory write port.
module tb_ofm_collector;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int M_IDLE  = 0;
    localparam int M_COLL  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [8:0]        total_cnt;
    logic              ofm_write;
    logic [DATA_W-1:0] ofm_data;
    logic              ofm_full;
    logic              mem_wr_en;
    logic [8:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              done;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, run phase and counters.
    logic [DATA_W-1:0] m_q[$];
    logic [24:0]       sb_q[$];
    int                m_state = M_IDLE;
    int                m_total = 0;
    int                m_acc = 0;
    int                m_wr = 0;
    logic              m_ovf = 1'b0;
    logic              m_wr_en, m_xfer, m_push;

    int                n_written = 0;
    int                rdy_mode = 0;
    logic              rdy_hold = 1'b0;
    int                rdy_pct = 100;

    logic              prev_stall = 1'b0;
    logic [8:0]        prev_addr;
    logic [DATA_W-1:0] prev_data;
    logic [24:0]       sb_e;

    ofm_collector #(
        .P      (4),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .total_cnt (total_cnt),
        .ofm_write (ofm_write),
        .ofm_data  (ofm_data),
        .ofm_full  (ofm_full),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: word-level view of the run, advanced once per rising edge.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            sb_q.delete();
            m_state = M_IDLE;
            m_total = 0;
            m_acc   = 0;
            m_wr    = 0;
            m_ovf   = 1'b0;
        end else begin
            m_wr_en = (m_state == M_COLL || m_state == M_DRAIN) && m_q.size() > 0;
            m_xfer  = m_wr_en && mem_ready;
            m_push  = (m_state == M_COLL) && ofm_write && m_q.size() < DEPTH;
            if (m_state == M_COLL && ofm_write && m_q.size() == DEPTH) m_ovf = 1'b1;
            if (m_xfer) begin
                void'(m_q.pop_front());
                m_wr++;
            end
            if (m_push) begin
                m_q.push_back(ofm_data);
                sb_q.push_back({m_acc[8:0], ofm_data});
                m_acc++;
            end
            if (m_state == M_IDLE || m_state == M_DONE) begin
                if (start) begin
                    m_total = int'(total_cnt);
                    m_acc   = 0;
                    m_wr    = 0;
                    m_ovf   = 1'b0;
                    m_state = (m_total == 0) ? M_DONE : M_COLL;
                end
            end else if (m_state == M_COLL) begin
                if (m_push && m_acc == m_total) m_state = M_DRAIN;
            end else if (m_xfer && m_wr == m_total) begin
                m_state = M_DONE;
            end
        end
    end

    // Monitor: compares DUT outputs with the model and drains the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("rst_ofm_full", ofm_full, 0);
            check("rst_mem_wr_en", mem_wr_en, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_done", done, 0);
            check("rst_overflow", overflow, 0);
            prev_stall = 1'b0;
        end else begin
            check("mem_wr_en", mem_wr_en, ((m_state == M_COLL || m_state == M_DRAIN)
                                           && m_q.size() > 0));
            check("ofm_full", ofm_full, (m_q.size() == DEPTH));
            check("done", done, (m_state == M_DONE));
            check("overflow", overflow, m_ovf);
            if (prev_stall) begin
                check("stall_wr_en", mem_wr_en, 1);
                check("stall_addr", mem_addr, prev_addr);
                check("stall_data", mem_wdata, prev_data);
            end
            if (mem_wr_en && mem_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("write_addr", mem_addr, sb_e[24:16]);
                    check("write_data", mem_wdata, sb_e[15:0]);
                end
                n_written++;
            end
            prev_stall = mem_wr_en && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       mem_ready = rdy_hold;
            1:       mem_ready = ~mem_ready;
            default: mem_ready = ($urandom_range(99) < rdy_pct);
        endcase
    endtask

    task automatic do_start(input int n);
        n_written = 0;
        start     = 1'b1;
        total_cnt = 9'(n);
        tick();
        start     = 1'b0;
    endtask

    task automatic put_word(input logic [DATA_W-1:0] d);
        ofm_write = 1'b1;
        ofm_data  = d;
        tick();
        ofm_write = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        rdy_mode  = 0;
        rdy_hold  = v;
        mem_ready = v;
    endtask

    task automatic wait_done(input string name, input int budget, input int exp_writes);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
        end
        check({name, "_done"}, done, 1);
        check({name, "_writes"}, n_written, exp_writes);
        check({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int wpct;
        rst       = 1'b1;
        start     = 1'b0;
        total_cnt = '0;
        ofm_write = 1'b0;
        ofm_data  = '0;
        mem_ready = 1'b0;
        repeat (3) tick();
        check("reset_done", done, 0);
        check("reset_wr_en", mem_wr_en, 0);
        rst = 1'b0;
        tick();

        // Four back-to-back words, memory always ready.
        set_ready(1'b1);
        do_start(4);
        for (int i = 0; i < 4; i++) put_word(DATA_W'(8'h11 * (i + 1)));
        wait_done("basic4", 50, 4);
        check("basic4_overflow", overflow, 0);

        // Memory stalled: FIFO fills, extra words dropped, run stays open.
        set_ready(1'b0);
        do_start(12);
        for (int i = 0; i < 12; i++) put_word(DATA_W'($urandom));
        check("ovf12_full", ofm_full, 1);
        check("ovf12_overflow", overflow, 1);
        set_ready(1'b1);
        repeat (30) tick();
        check("ovf12_writes", n_written, 8);
        check("ovf12_not_done", done, 0);
        check("ovf12_empty", ofm_full, 0);
        pulse_rst();

        // Alternating ready.
        rdy_mode = 1;
        do_start(6);
        for (int i = 0; i < 6; i++) put_word(DATA_W'($urandom));
        wait_done("toggle6", 100, 6);

        // Empty run.
        set_ready(1'b1);
        do_start(0);
        check("zero_done", done, 1);
        repeat (3) tick();
        check("zero_writes", n_written, 0);

        // Asynchronous abort mid-run, then a fresh short run.
        set_ready(1'b0);
        do_start(5);
        for (int i = 0; i < 3; i++) put_word(DATA_W'($urandom));
        #2 rst = 1'b1;
        #1;
        check("abort_ofm_full", ofm_full, 0);
        check("abort_wr_en", mem_wr_en, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        check("abort_done", done, 0);
        check("abort_overflow", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        set_ready(1'b1);
        do_start(2);
        for (int i = 0; i < 2; i++) put_word(DATA_W'($urandom));
        wait_done("after_abort", 50, 2);

        // Start during drain must be ignored.
        set_ready(1'b0);
        do_start(4);
        for (int i = 0; i < 4; i++) put_word(DATA_W'($urandom));
        start     = 1'b1;
        total_cnt = 9'd7;
        tick();
        start     = 1'b0;
        check("drain_start_not_done", done, 0);
        set_ready(1'b1);
        wait_done("drain_start", 50, 4);

        // Random runs.
        for (int r = 0; r < 12; r++) begin
            rdy_mode = 2;
            rdy_pct  = $urandom_range(100, 20);
            n        = $urandom_range(24, 1);
            wpct     = $urandom_range(100, 30);
            do_start(n);
            for (int c = 0; c < 400 && m_state == M_COLL; c++) begin
                ofm_write = ($urandom_range(99) < wpct);
                ofm_data  = DATA_W'($urandom);
                tick();
            end
            ofm_write = 1'b0;
            wait_done("random", 2000, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
